// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 8-bit core.
// Owns the program counter and drives the synchronous program ROM.
// It issues one instruction every three cycles (FETCH, LATCH, EXEC).
// The instruction is presented to the decoder only during EXEC.
// The decoder's jump request is applied at the edge that ends EXEC.
module instruction_fetch #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH-1:0]          prog_adr,
    output logic                         prog_rd_en,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    input  logic                         stall,
    input  logic                         cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    output logic [PC_WIDTH-1:0]          pc
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0]          PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PROGRAM_DataWidth-1:0] NOP    = {PROGRAM_DataWidth{1'b0}};

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [PROGRAM_DataWidth-1:0]   ir_q, ir_d;
    logic                           instr_valid_q;
    logic [PROGRAM_DataWidth-1:0]   instruction_q;
    logic                           rd_en_s;

    // Next-state, next-PC, IR capture and ROM read strobe.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rd_en_s = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A stall only holds off a fetch that has not started yet.
                if (!stall) begin
                    rd_en_s = 1'b1;
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LATCH: begin
                // ROM data for the address read in FETCH is valid now.
                ir_d    = prog_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // The decoder is combinational, so its jump request refers to
                // the instruction issued in this same cycle.
                if (cnt_wr_en) begin
                    pc_d = literal_adr;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State, PC, IR and registered decoder-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESET;
            pc_q          <= {PC_WIDTH{1'b0}};
            ir_q          <= NOP;
            instr_valid_q <= 1'b0;
            instruction_q <= NOP;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            // The instruction is shown only during EXEC; every other cycle
            // carries a NOP so the decoder cannot act on stale data.
            instr_valid_q <= (state_d == ST_EXEC);
            instruction_q <= (state_d == ST_EXEC) ? ir_d : NOP;
        end
    end

    assign prog_adr    = pc_q;
    assign prog_rd_en  = rd_en_s;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a 1-cycle ROM model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  prog_adr;
    logic        prog_rd_en;
    logic [15:0] prog_data;
    logic        stall;
    logic        cnt_wr_en;
    logic [7:0]  literal_adr;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;

    logic [15:0] rom [256];
    int checks;
    int errors;

    instruction_fetch #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_adr    (prog_adr),
        .prog_rd_en  (prog_rd_en),
        .prog_data   (prog_data),
        .stall       (stall),
        .cnt_wr_en   (cnt_wr_en),
        .literal_adr (literal_adr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the sampled address appears next cycle.
    always @(posedge clk) begin
        if (prog_rd_en) prog_data <= rom[prog_adr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the middle of the next cycle and apply inputs for that cycle.
    task automatic step(input logic r, input logic s, input logic c, input logic [7:0] la);
        @(negedge clk);
        rst = r; stall = s; cnt_wr_en = c; literal_adr = la;
        #1;
    endtask

    // Compare every output against the expected values for this cycle.
    task automatic expect_cyc(input string tag, input logic rd, input logic [7:0] adr,
                              input logic vld, input logic [15:0] ins, input logic [7:0] epc);
        check({tag, ".rd_en"}, {31'd0, prog_rd_en}, {31'd0, rd});
        check({tag, ".adr"},   {24'd0, prog_adr},   {24'd0, adr});
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
        check({tag, ".instr"}, {16'd0, instruction}, {16'd0, ins});
        check({tag, ".pc"},    {24'd0, pc},          {24'd0, epc});
    endtask

    // One complete, unstalled instruction at address a; jump request in EXEC.
    task automatic run_instr(input string tag, input logic [7:0] a,
                             input logic c, input logic [7:0] la);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc({tag, ".F"}, 1'b1, a, 1'b0, 16'h0000, a);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc({tag, ".L"}, 1'b0, a, 1'b0, 16'h0000, a);
        step(1'b0, 1'b0, c, la);
        expect_cyc({tag, ".E"}, 1'b0, a, 1'b1, rom[a], a);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; stall = 1'b0; cnt_wr_en = 1'b0; literal_adr = 8'h00;
        prog_data = 16'h0000;
        for (int i = 0; i < 256; i++) rom[i] = {8'(i) ^ 8'hA5, 8'(i)};
        rom[0] = 16'h0A10;
        rom[1] = 16'h4D18;
        rom[2] = 16'h0000;

        // Power-on reset.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        expect_cyc("por", 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc("por_rel", 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);

        // Sequential fetch of addresses 0..2, then a jump from pc 3 to 3F.
        run_instr("seq0", 8'h00, 1'b0, 8'h00);
        run_instr("seq1", 8'h01, 1'b0, 8'h00);
        run_instr("seq2", 8'h02, 1'b0, 8'h00);
        run_instr("jmp3", 8'h03, 1'b1, 8'h3F);
        // Jump target, then jump to the top of the address space.
        run_instr("t3f", 8'h3F, 1'b1, 8'hFF);
        // No jump at FF: PC wraps to 0. From 0 jump to 5.
        run_instr("tff", 8'hFF, 1'b0, 8'h00);
        run_instr("wrap", 8'h00, 1'b1, 8'h05);

        // Stall for 4 cycles in FETCH at pc 5.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            expect_cyc("stall", 1'b0, 8'h05, 1'b0, 16'h0000, 8'h05);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc("stall_rel.F", 1'b1, 8'h05, 1'b0, 16'h0000, 8'h05);
        // A stall in LATCH and EXEC must not delay the instruction in flight.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        expect_cyc("stall_l.L", 1'b0, 8'h05, 1'b0, 16'h0000, 8'h05);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        expect_cyc("stall_l.E", 1'b0, 8'h05, 1'b1, rom[8'h05], 8'h05);

        // Jump to current PC (6 after increment is next; use self-jump at 6).
        run_instr("self6", 8'h06, 1'b1, 8'h06);

        // Reset asserted in the EXEC of a jump to 20, held 2 cycles.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc("rx.F", 1'b1, 8'h06, 1'b0, 16'h0000, 8'h06);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc("rx.L", 1'b0, 8'h06, 1'b0, 16'h0000, 8'h06);
        step(1'b1, 1'b0, 1'b1, 8'h20);
        expect_cyc("rx.E", 1'b0, 8'h06, 1'b1, rom[8'h06], 8'h06);
        step(1'b1, 1'b0, 1'b1, 8'h20);
        expect_cyc("rx.r1", 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        expect_cyc("rx.r2", 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);
        run_instr("rx.after", 8'h00, 1'b0, 8'h00);
        run_instr("rx.next", 8'h01, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
